// File: rtl/query_weight_dot_accumulator.sv
// Streaming signed dot-product accumulator: IN_DEPTH beats of PARALLELISM lane products per result.
// Optional macro QUERY_DOT_ACC_RELU_EN clamps negative results to zero.
module query_weight_dot_accumulator #(
    parameter int DATA_IN_PRECISION_0  = 16,
    parameter int DATA_IN_PRECISION_1  = 3,
    parameter int WEIGHT_PRECISION_0   = 16,
    parameter int WEIGHT_PRECISION_1   = 3,
    parameter int PARALLELISM          = 1,
    parameter int IN_DEPTH             = 32,
    parameter int DATA_OUT_PRECISION_0 = DATA_IN_PRECISION_0 + WEIGHT_PRECISION_0
                                         + $clog2(PARALLELISM * IN_DEPTH),
    parameter int DATA_OUT_PRECISION_1 = DATA_IN_PRECISION_1 + WEIGHT_PRECISION_1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic signed [DATA_IN_PRECISION_0-1:0]  data_in [PARALLELISM],
    input  logic                                   data_in_valid,
    output logic                                   data_in_ready,
    input  logic signed [WEIGHT_PRECISION_0-1:0]   weight [PARALLELISM],
    input  logic                                   weight_valid,
    output logic                                   weight_ready,
    output logic signed [DATA_OUT_PRECISION_0-1:0] data_out,
    output logic                                   data_out_valid,
    input  logic                                   data_out_ready
);

    localparam int DO_W   = DATA_OUT_PRECISION_0;
    localparam int PROD_W = DATA_IN_PRECISION_0 + WEIGHT_PRECISION_0;
    localparam int CNT_W  = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;

    // The fixed-point result must still have at least one integer bit.
    if (DATA_OUT_PRECISION_1 >= DATA_OUT_PRECISION_0) begin : g_bad_frac
        $error("fraction bits exceed output width");
    end

    logic [CNT_W-1:0]       count_q, count_d;
    logic signed [DO_W-1:0] acc_q, acc_d;
    logic signed [DO_W-1:0] out_q, out_d;
    logic                   valid_q, valid_d;

    logic                   stall, fire, last_beat;
    logic signed [DO_W-1:0] beat_sum, total, result;

    // Handshake: both streams are taken together on fire; a held result blocks everything.
    assign stall         = valid_q & ~data_out_ready;
    assign fire          = data_in_valid & weight_valid & ~stall;
    assign data_in_ready = weight_valid & ~stall;
    assign weight_ready  = data_in_valid & ~stall;
    assign last_beat     = (count_q == CNT_W'(IN_DEPTH - 1));

    always_comb begin
        logic signed [PROD_W-1:0] prod;
        beat_sum = '0;
        prod     = '0;
        for (int i = 0; i < PARALLELISM; i++) begin
            prod     = PROD_W'(data_in[i]) * PROD_W'(weight[i]);
            beat_sum = beat_sum + DO_W'(prod);
        end
    end

    assign total = acc_q + beat_sum;

`ifdef QUERY_DOT_ACC_RELU_EN
    assign result = total[DO_W-1] ? '0 : total;
`else
    assign result = total;
`endif

    always_comb begin
        count_d = count_q;
        acc_d   = acc_q;
        out_d   = out_q;
        valid_d = valid_q;
        if (valid_q && data_out_ready) begin
            valid_d = 1'b0;
        end
        if (fire) begin
            if (last_beat) begin
                count_d = '0;
                acc_d   = '0;
                out_d   = result;
                valid_d = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
                acc_d   = total;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            count_q <= count_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign data_out       = out_q;
    assign data_out_valid = valid_q;

endmodule

// File: tb/tb_query_weight_dot_accumulator.sv
// Directed bench for query_weight_dot_accumulator with PARALLELISM=2, IN_DEPTH=4.
// Expected values are hand-computed; negative rows become 0 when QUERY_DOT_ACC_RELU_EN is defined.
module tb_query_weight_dot_accumulator;

    localparam int P    = 2;
    localparam int D    = 4;
    localparam int DO_W = 35;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic signed [15:0]     data_in [P];
    logic                   data_in_valid = 1'b0;
    logic                   data_in_ready;
    logic signed [15:0]     weight [P];
    logic                   weight_valid = 1'b0;
    logic                   weight_ready;
    logic signed [DO_W-1:0] data_out;
    logic                   data_out_valid;
    logic                   data_out_ready = 1'b1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic signed [15:0] a;
        logic signed [15:0] w;
        logic signed [63:0] exp;
    } vec_t;

    vec_t tbl [5];

    query_weight_dot_accumulator #(
        .PARALLELISM(P),
        .IN_DEPTH   (D)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .weight        (weight),
        .weight_valid  (weight_valid),
        .weight_ready  (weight_ready),
        .data_out      (data_out),
        .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_lanes(input logic signed [15:0] a, input logic signed [15:0] w);
        for (int i = 0; i < P; i++) begin
            data_in[i] = a;
            weight[i]  = w;
        end
    endtask

    initial begin
        tbl[0] = '{a: 16'sd1,      w: 16'sd2,      exp: 64'sd16};
`ifdef QUERY_DOT_ACC_RELU_EN
        tbl[1] = '{a: -16'sd3,     w: 16'sd5,      exp: 64'sd0};
        tbl[3] = '{a: 16'sd3,      w: -16'sd7,     exp: 64'sd0};
`else
        tbl[1] = '{a: -16'sd3,     w: 16'sd5,      exp: -64'sd120};
        tbl[3] = '{a: 16'sd3,      w: -16'sd7,     exp: -64'sd168};
`endif
        tbl[2] = '{a: -16'sd32768, w: -16'sd32768, exp: 64'sd8589934592};
        tbl[4] = '{a: 16'sd1,      w: 16'sd2,      exp: 64'sd16};

        set_lanes(16'sd0, 16'sd0);

        // reset state and ready wiring
        step();
        step();
        rst = 1'b0;
        #1;
        chk("reset_valid", data_out_valid, 0);
        chk("reset_data", data_out, 0);
        chk("reset_in_ready_no_wvalid", data_in_ready, 0);
        weight_valid = 1'b1;
        #1;
        chk("reset_in_ready_wvalid", data_in_ready, 1);
        chk("reset_w_ready_no_dvalid", weight_ready, 0);
        weight_valid = 1'b0;
        step();

        // table rows streamed back to back, one result every 4 cycles
        data_in_valid = 1'b1;
        weight_valid  = 1'b1;
        for (int r = 0; r < 5; r++) begin
            set_lanes(tbl[r].a, tbl[r].w);
            for (int b = 0; b < D; b++) begin
                step();
                if (b == 0 && r > 0) chk($sformatf("row%0d_valid_cleared", r), data_out_valid, 0);
            end
            chk($sformatf("row%0d_valid", r), data_out_valid, 1);
            chk($sformatf("row%0d_data", r), data_out, tbl[r].exp);
        end
        data_in_valid = 1'b0;
        weight_valid  = 1'b0;
        step();
        chk("idle_valid_cleared", data_out_valid, 0);
        chk("idle_data_held", data_out, 16);

        // weight stream stalls mid-block: no fire, counter frozen
        set_lanes(16'sd1, 16'sd2);
        data_in_valid = 1'b1;
        weight_valid  = 1'b1;
        step();
        weight_valid = 1'b0;
        #1;
        chk("wstall_in_ready", data_in_ready, 0);
        chk("wstall_w_ready", weight_ready, 1);
        for (int k = 0; k < 3; k++) step();
        chk("wstall_no_result", data_out_valid, 0);
        weight_valid = 1'b1;
        step();
        step();
        chk("wstall_3fires_no_result", data_out_valid, 0);
        step();
        chk("wstall_result_valid", data_out_valid, 1);
        chk("wstall_result_data", data_out, 16);

        // downstream backpressure holds the result and blocks both inputs
        data_out_ready = 1'b0;
        #1;
        chk("bp_in_ready", data_in_ready, 0);
        chk("bp_w_ready", weight_ready, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("bp_hold_valid%0d", k), data_out_valid, 1);
            chk($sformatf("bp_hold_data%0d", k), data_out, 16);
        end
        data_out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", data_in_ready, 1);
        chk("bp_release_w_ready", weight_ready, 1);
        step();
        chk("bp_consumed", data_out_valid, 0);
        for (int k = 0; k < 3; k++) step();
        chk("bp_next_valid", data_out_valid, 1);
        chk("bp_next_data", data_out, 16);

        // reset after two fires discards the partial sum
        step();
        step();
        chk("pre_rst_data", data_out, 16);
        data_in_valid = 1'b0;
        weight_valid  = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("rst_mid_valid", data_out_valid, 0);
        chk("rst_mid_data", data_out, 0);
        data_in_valid = 1'b1;
        weight_valid  = 1'b1;
        for (int k = 0; k < 3; k++) step();
        chk("post_rst_early", data_out_valid, 0);
        step();
        chk("post_rst_valid", data_out_valid, 1);
        chk("post_rst_data", data_out, 16);

        // reset wins over a simultaneous fire and a pending result
        rst = 1'b1;
        step();
        rst = 1'b0;
        data_in_valid = 1'b0;
        weight_valid  = 1'b0;
        #1;
        chk("rst_fire_valid", data_out_valid, 0);
        chk("rst_fire_data", data_out, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
